fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_pkg.sv | 20 ++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch sequencer: datapath widths, FSM encodings
// and the address-to-line helper used by the fetch PC logic.
package fetch_sequencer_pkg;

  localparam int ADDR_LEN = 32;
  localparam int INSN_LEN = 32;
  localparam int LINE_LEN = ADDR_LEN - 4;
  localparam int DATA_LEN = 4 * INSN_LEN;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;
  localparam logic [1:0] ST_DROP  = 2'd3;

  // A line is 16 bytes, so the line address is the PC without its low nibble.
  function automatic logic [LINE_LEN-1:0] line_of(input logic [ADDR_LEN-1:0] addr);
    return addr[ADDR_LEN-1:4];
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, requests 16-byte lines from
// instruction memory, buffers one line and squashes responses made stale by redirects.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [ADDR_LEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                reset,
  output logic [ADDR_LEN-1:0] pc,
  input  logic [ADDR_LEN-1:0] npc,
  input  logic                prmiss,
  input  logic [ADDR_LEN-1:0] jmpaddr,
  input  logic                stall_IF,
  output logic                imem_req,
  output logic [LINE_LEN-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [DATA_LEN-1:0] imem_rdata,
  output logic [DATA_LEN-1:0] idata,
  output logic                fetch_valid
);

  logic [1:0]          state_r;
  logic [ADDR_LEN-1:0] pc_r;
  logic [DATA_LEN-1:0] idata_r;
  logic [LINE_LEN-1:0] line_tag_r;
  logic [LINE_LEN-1:0] req_line_r;
  logic                imem_req_r;
  logic [LINE_LEN-1:0] imem_addr_r;
  logic                fetch_valid_r;

  logic [1:0]          state_s;
  logic [ADDR_LEN-1:0] pc_s;
  logic [DATA_LEN-1:0] idata_s;
  logic [LINE_LEN-1:0] line_tag_s;
  logic [LINE_LEN-1:0] req_line_s;

  // Next-state logic; a redirect always wins over consume and line reuse.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    idata_s    = idata_r;
    line_tag_s = line_tag_r;
    req_line_s = req_line_r;
    case (state_r)
      ST_BOOT: begin
        state_s = ST_REQ;
      end
      ST_REQ: begin
        if (prmiss && imem_ack) begin
          pc_s    = jmpaddr;
          state_s = ST_REQ;
        end else if (prmiss) begin
          // The request cannot be withdrawn, so park its line and wait for it.
          req_line_s = line_of(pc_r);
          pc_s       = jmpaddr;
          state_s    = ST_DROP;
        end else if (imem_ack) begin
          idata_s    = imem_rdata;
          line_tag_s = line_of(pc_r);
          state_s    = ST_VALID;
        end else begin
          state_s = ST_REQ;
        end
      end
      ST_VALID: begin
        if (prmiss) begin
          pc_s    = jmpaddr;
          state_s = ST_REQ;
        end else if (!stall_IF) begin
          pc_s = npc;
          if (line_of(npc) == line_tag_r) begin
            state_s = ST_VALID;
          end else begin
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_VALID;
        end
      end
      ST_DROP: begin
        if (imem_ack) begin
          if (prmiss) begin
            pc_s = jmpaddr;
          end else begin
            pc_s = pc_r;
          end
          state_s = ST_REQ;
        end else if (prmiss) begin
          pc_s    = jmpaddr;
          state_s = ST_DROP;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_BOOT;
      end
    endcase
  end

  // State, PC, line buffer and output registers; outputs are decoded from next state
  // so that they reflect the registered state without any combinational path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_PC;
      idata_r       <= '0;
      line_tag_r    <= '0;
      req_line_r    <= '0;
      imem_req_r    <= 1'b0;
      imem_addr_r   <= '0;
      fetch_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      idata_r       <= idata_s;
      line_tag_r    <= line_tag_s;
      req_line_r    <= req_line_s;
      imem_req_r    <= (state_s == ST_REQ) || (state_s == ST_DROP);
      imem_addr_r   <= (state_s == ST_DROP) ? req_line_s : line_of(pc_s);
      fetch_valid_r <= (state_s == ST_VALID);
    end
  end

  assign pc          = pc_r;
  assign idata       = idata_r;
  assign imem_req    = imem_req_r;
  assign imem_addr   = imem_addr_r;
  assign fetch_valid = fetch_valid_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a transaction-level model of the fetch PC,
// the outstanding memory request and the line buffer is compared every cycle.
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  pc;
  logic [31:0]  npc = 32'h0;
  logic         prmiss = 1'b0;
  logic [31:0]  jmpaddr = 32'h0;
  logic         stall_IF = 1'b1;
  logic         imem_req;
  logic [27:0]  imem_addr;
  logic         imem_ack = 1'b0;
  logic [127:0] imem_rdata = 128'h0;
  logic [127:0] idata;
  logic         fetch_valid;

  int errors = 0;
  int checks = 0;

  fetch_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .pc(pc), .npc(npc), .prmiss(prmiss),
    .jmpaddr(jmpaddr), .stall_IF(stall_IF), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .idata(idata), .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] line_data(input logic [27:0] a);
    return {4'hA, a, 4'hB, a, 4'hC, a, 4'hD, a};
  endfunction

  // Model: what the fetch unit holds, expressed as "an outstanding request for
  // some line, possibly already stale" plus "a buffered line and its tag".
  typedef struct packed {
    logic [31:0]  pc;
    logic         booting;
    logic         outstanding;
    logic         stale;
    logic [27:0]  req_line;
    logic         have_line;
    logic [127:0] line;
    logic [27:0]  tag;
  } model_t;

  model_t m;

  function automatic model_t issue(input model_t s);
    model_t n = s;
    n.outstanding = 1'b1;
    n.stale       = 1'b0;
    n.req_line    = s.pc[31:4];
    n.have_line   = 1'b0;
    return n;
  endfunction

  function automatic model_t model_next(input model_t s, input logic rst, input logic ack,
                                        input logic pm, input logic [31:0] jmp,
                                        input logic stall, input logic [31:0] nxt,
                                        input logic [127:0] rdata);
    model_t n = s;
    if (rst) begin
      n = '0;
      n.pc      = RST_PC;
      n.booting = 1'b1;
    end else if (s.booting) begin
      n.booting = 1'b0;
      n = issue(n);
    end else if (s.outstanding) begin
      if (ack && !s.stale && !pm) begin
        n.outstanding = 1'b0;
        n.have_line   = 1'b1;
        n.line        = rdata;
        n.tag         = s.req_line;
      end else if (ack) begin
        if (pm) n.pc = jmp;
        n = issue(n);
      end else if (pm) begin
        n.pc    = jmp;
        n.stale = 1'b1;
      end
    end else if (pm) begin
      n.pc = jmp;
      n = issue(n);
    end else if (!stall) begin
      n.pc = nxt;
      if (nxt[31:4] != s.tag) n = issue(n);
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= model_next(m, reset, imem_ack, prmiss, jmpaddr, stall_IF, npc, imem_rdata);

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("m_pc", {96'h0, pc}, {96'h0, m.pc});
    check("m_imem_req", {127'h0, imem_req}, {127'h0, m.outstanding});
    check("m_fetch_valid", {127'h0, fetch_valid}, {127'h0, m.have_line});
    check("m_idata", idata, m.line);
    if (m.outstanding) check("m_imem_addr", {100'h0, imem_addr}, {100'h0, m.req_line});
  endtask

  task automatic step(input logic rst_v, input logic ack_v, input logic pm_v,
                      input logic [31:0] jmp_v, input logic st_v, input logic [31:0] npc_v);
    reset      = rst_v;
    imem_ack   = ack_v;
    prmiss     = pm_v;
    jmpaddr    = jmp_v;
    stall_IF   = st_v;
    npc        = npc_v;
    imem_rdata = line_data(imem_addr);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle();                       step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0); endtask
  task automatic ack();                        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0); endtask
  task automatic consume(input logic [31:0] n); step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, n);    endtask
  task automatic redirect(input logic [31:0] j); step(1'b0, 1'b0, 1'b1, j, 1'b1, 32'h0);   endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("rst_req", {127'h0, imem_req}, 128'h0);
    check("rst_valid", {127'h0, fetch_valid}, 128'h0);
    check("rst_idata", idata, 128'h0);
    check("rst_pc", {96'h0, pc}, 128'h100);

    idle();
    check("boot_req", {127'h0, imem_req}, 128'h1);
    check("boot_addr", {100'h0, imem_addr}, 128'h10);
    idle();
    ack();
    check("first_valid", {127'h0, fetch_valid}, 128'h1);
    check("first_idata", idata, line_data(28'h10));

    consume(32'h108);
    check("hit_pc", {96'h0, pc}, 128'h108);
    check("hit_valid", {127'h0, fetch_valid}, 128'h1);
    check("hit_noreq", {127'h0, imem_req}, 128'h0);
    consume(32'h110);
    check("miss_addr", {100'h0, imem_addr}, 128'h11);
    check("miss_valid", {127'h0, fetch_valid}, 128'h0);
    idle();
    ack();

    for (int i = 0; i < 5; i++) begin
      idle();
      check("stall_pc", {96'h0, pc}, 128'h110);
      check("stall_idata", idata, line_data(28'h11));
    end
    redirect(32'h200);
    check("stall_redir_pc", {96'h0, pc}, 128'h200);
    check("stall_redir_addr", {100'h0, imem_addr}, 128'h20);

    redirect(32'h400);
    check("drop_addr_held", {100'h0, imem_addr}, 128'h20);
    idle();
    idle();
    ack();
    check("drop_discard", {127'h0, fetch_valid}, 128'h0);
    check("drop_next_addr", {100'h0, imem_addr}, 128'h40);
    idle();
    ack();
    check("drop_refill", idata, line_data(28'h40));

    consume(32'h500);
    step(1'b0, 1'b1, 1'b1, 32'h600, 1'b1, 32'h0);
    check("coinc_valid", {127'h0, fetch_valid}, 128'h0);
    check("coinc_addr", {100'h0, imem_addr}, 128'h60);
    ack();

    consume(32'h700);
    redirect(32'h800);
    redirect(32'h900);
    check("drop_pm_addr", {100'h0, imem_addr}, 128'h70);
    step(1'b0, 1'b1, 1'b1, 32'hA00, 1'b1, 32'h0);
    check("drop_ackpm_pc", {96'h0, pc}, 128'hA00);
    check("drop_ackpm_addr", {100'h0, imem_addr}, 128'hA0);
    ack();

    redirect(32'hFFFF_FFF0);
    ack();
    consume(32'hFFFF_FFF8);
    check("wrap_hit", {127'h0, fetch_valid}, 128'h1);
    consume(32'h0000_0000);
    check("wrap_addr", {100'h0, imem_addr}, 128'h0);
    check("wrap_req", {127'h0, imem_req}, 128'h1);
    ack();

    consume(32'h30);
    redirect(32'h40);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0);
    check("drop_rst_req", {127'h0, imem_req}, 128'h0);
    check("drop_rst_pc", {96'h0, pc}, 128'h100);
    idle();
    idle();
    ack();
    check("recover_idata", idata, line_data(28'h10));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
